// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side burst controller for the async FIFO, streaming bursts through a 2-entry skid buffer.
// Optional feature macro: FIFO_BURST_READER_TIMEOUT_EN starts a partial burst after TIMEOUT idle cycles with data.
module fifo_burst_reader #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 9,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 256
) (
    input  logic              read_clock,
    input  logic              reset_n,
    input  logic              fifo_empty,
    input  logic [AWIDTH-1:0] fifo_depth,
    input  logic [DWIDTH-1:0] fifo_read_data,
    output logic              fifo_read_enable,
    output logic              fifo_flush,
    input  logic              flush_req,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BURST, WAIT_OUT, FLUSH} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [AWIDTH-1:0] r_remaining;
    logic [DWIDTH-1:0] r_buf0_data;
    logic [DWIDTH-1:0] r_buf1_data;
    logic              r_buf0_last;
    logic              r_buf1_last;
    logic [1:0]        r_buf_cnt;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_pop;
    logic              w_clear;
    logic              w_full_ready;
    logic              w_start_full;
    logic              w_start_timeout;
    logic              w_last_read;
    logic [1:0]        w_cnt_after_pop;
    logic [2:0]        w_occupancy;

    assign w_pop           = m_valid && m_ready;
    assign w_clear         = flush_req || (r_state == FLUSH);
    assign w_full_ready    = (fifo_depth >= AWIDTH'(BURST_LEN));
    assign w_start_full    = (r_state == IDLE) && w_full_ready;
    assign w_cnt_after_pop = r_buf_cnt - {1'b0, w_pop};
    // Buffered words plus the word still coming out of the FIFO, after this cycle's pop.
    assign w_occupancy     = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_last_read     = fifo_read_enable && (r_remaining == AWIDTH'(1));

    assign m_valid = (r_buf_cnt != 2'd0);
    assign m_data  = m_valid ? r_buf0_data : '0;
    assign m_last  = m_valid && r_buf0_last;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] r_timer;

    assign w_start_timeout = (r_state == IDLE) && !w_full_ready &&
                             (r_timer == TW'(TIMEOUT - 1)) && (fifo_depth != '0);

    // Counts idle cycles with data waiting; saturates at TIMEOUT-1.
    always_ff @(posedge read_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (w_clear || (r_state != IDLE) || fifo_empty || w_start_full || w_start_timeout) begin
            r_timer <= '0;
        end else if (r_timer != TW'(TIMEOUT - 1)) begin
            r_timer <= r_timer + TW'(1);
        end
    end
`else
    logic w_unused_timeout;

    assign w_start_timeout  = 1'b0;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        w_next_state     = r_state;
        fifo_read_enable = 1'b0;
        fifo_flush       = 1'b0;
        busy             = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_start_full || w_start_timeout)
                    w_next_state = BURST;
            end
            BURST: begin
                fifo_read_enable = !fifo_empty && (r_remaining != '0) && (w_occupancy < 3'd2);
                if (fifo_read_enable && (r_remaining == AWIDTH'(1)))
                    w_next_state = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (w_pop && m_last)
                    w_next_state = IDLE;
            end
            FLUSH: begin
                fifo_flush   = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (flush_req)
            w_next_state = FLUSH;
    end

    always_ff @(posedge read_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_clear)
                r_remaining <= '0;
            else if (w_start_full)
                r_remaining <= AWIDTH'(BURST_LEN);
            else if (w_start_timeout)
                r_remaining <= fifo_depth;
            else if (fifo_read_enable)
                r_remaining <= r_remaining - AWIDTH'(1);
        end
    end

    // Entry 0 is the head; the word landing from the FIFO goes into the first free slot after any pop.
    always_ff @(posedge read_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_buf0_data     <= '0;
            r_buf1_data     <= '0;
            r_buf0_last     <= 1'b0;
            r_buf1_last     <= 1'b0;
            r_buf_cnt       <= 2'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else if (w_clear) begin
            r_buf0_last     <= 1'b0;
            r_buf1_last     <= 1'b0;
            r_buf_cnt       <= 2'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_pop) begin
                r_buf0_data <= r_buf1_data;
                r_buf0_last <= r_buf1_last;
                r_buf1_last <= 1'b0;
            end
            if (r_inflight) begin
                if (w_cnt_after_pop == 2'd0) begin
                    r_buf0_data <= fifo_read_data;
                    r_buf0_last <= r_inflight_last;
                end else begin
                    r_buf1_data <= fifo_read_data;
                    r_buf1_last <= r_inflight_last;
                end
            end
            r_buf_cnt       <= w_cnt_after_pop + {1'b0, r_inflight};
            r_inflight      <= fifo_read_enable;
            r_inflight_last <= w_last_read;
        end
    end

endmodule
